// File: rtl/join_match_mem.sv
// join_match_mem: dataflow operand matching store. One packet at a time is
// looked up against 64 stored operands; an external controller picks the
// entry to write or consume. Joined or bypassed packets leave through a
// valid/ready output register.
module join_match_mem #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int DATA_W  = 16
) (
  input  logic                CP,
  input  logic                MR,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                IN_MF,
  input  logic                IN_LR,
  input  logic [TAG_W-1:0]    IN_TAG,
  input  logic [DATA_W-1:0]   IN_DATA,
  output logic [ENTRIES-1:0]  FIRE,
  output logic [ENTRIES-1:0]  VALID,
  output logic                MF,
  input  logic                WR_E,
  input  logic                DEL,
  input  logic [5:0]          ADDR,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [TAG_W-1:0]    OUT_TAG,
  output logic [DATA_W-1:0]   OUT_DL,
  output logic [DATA_W-1:0]   OUT_DR,
  output logic                OVF
);

  typedef enum logic [1:0] {IDLE, LOOK, COMMIT, EMIT} state_t;

  state_t r_state;
  state_t w_next;

  // Packet in flight.
  logic              r_pkt_mf;
  logic              r_pkt_lr;
  logic [TAG_W-1:0]  r_pkt_tag;
  logic [DATA_W-1:0] r_pkt_data;

  // Entry storage; only the occupancy flags are reset.
  logic [ENTRIES-1:0] r_vld;
  logic               r_ent_lr   [ENTRIES];
  logic [TAG_W-1:0]   r_ent_tag  [ENTRIES];
  logic [DATA_W-1:0]  r_ent_data [ENTRIES];

  logic [TAG_W-1:0]  r_out_tag;
  logic [DATA_W-1:0] r_out_dl;
  logic [DATA_W-1:0] r_out_dr;
  logic              r_ovf;

  logic w_commit_match;
  logic w_full;
  logic w_write;
  logic w_ovf;
  logic w_del;
  logic w_bypass;

  assign w_commit_match = (r_state == COMMIT) && r_pkt_mf;
  assign w_full         = &r_vld;
  assign w_write        = w_commit_match && WR_E && !w_full;
  assign w_ovf          = w_commit_match && WR_E && w_full;
  assign w_del          = w_commit_match && !WR_E && DEL;
  assign w_bypass       = (r_state == COMMIT) && !r_pkt_mf;

  assign VALID   = r_vld;
  assign MF      = (r_state == LOOK) ? r_pkt_mf : 1'b1;
  assign OUT_TAG = r_out_tag;
  assign OUT_DL  = r_out_dl;
  assign OUT_DR  = r_out_dr;
  assign OVF     = r_ovf;

  // State register.
  always_ff @(posedge CP or posedge MR) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (MR) r_state <= IDLE;
    else    r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_next    = r_state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    unique case (r_state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) w_next = LOOK;
      end
      LOOK: w_next = COMMIT;
      COMMIT: begin
        if (!r_pkt_mf)  w_next = EMIT;
        else if (WR_E)  w_next = IDLE;
        else if (DEL)   w_next = EMIT;
        else            w_next = IDLE;
      end
      EMIT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Per-entry match against the packet, only while looking up.
  always_comb begin
    FIRE = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      FIRE[i] = r_vld[i] && (r_ent_tag[i] == r_pkt_tag) &&
                (r_ent_lr[i] != r_pkt_lr) && r_pkt_mf && (r_state == LOOK);
    end
  end

  // Packet capture, occupancy flags, output register and sticky overflow.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_pkt_mf   <= 1'b0;
      r_pkt_lr   <= 1'b0;
      r_pkt_tag  <= '0;
      r_pkt_data <= '0;
      r_vld      <= '0;
      r_out_tag  <= '0;
      r_out_dl   <= '0;
      r_out_dr   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state == IDLE && IN_VALID) begin
        r_pkt_mf   <= IN_MF;
        r_pkt_lr   <= IN_LR;
        r_pkt_tag  <= IN_TAG;
        r_pkt_data <= IN_DATA;
      end
      if (w_bypass) begin
        r_out_tag <= r_pkt_tag;
        r_out_dl  <= r_pkt_lr ? '0 : r_pkt_data;
        r_out_dr  <= r_pkt_lr ? r_pkt_data : '0;
      end
      if (w_write) r_vld[ADDR] <= 1'b1;
      if (w_ovf)   r_ovf <= 1'b1;
      if (w_del) begin
        r_vld[ADDR] <= 1'b0;
        r_out_tag   <= r_pkt_tag;
        r_out_dl    <= r_pkt_lr ? r_ent_data[ADDR] : r_pkt_data;
        r_out_dr    <= r_pkt_lr ? r_pkt_data : r_ent_data[ADDR];
      end
    end
  end

  // Entry payload write.
  always_ff @(posedge CP) begin
    // NOTE: the payload array has no reset; its contents are only trusted
    // where r_vld is set, which keeps it a plain RAM.
    if (w_write) begin
      r_ent_lr[ADDR]   <= r_pkt_lr;
      r_ent_tag[ADDR]  <= r_pkt_tag;
      r_ent_data[ADDR] <= r_pkt_data;
    end
  end

endmodule

// File: tb/tb_join_match_mem.sv
// Directed bench for join_match_mem; the bench itself plays the controller.
module tb_join_match_mem;

  localparam int TAG_W  = 10;
  localparam int DATA_W = 16;

  logic              CP = 1'b0;
  logic              MR;
  logic              IN_VALID, IN_READY, IN_MF, IN_LR;
  logic [TAG_W-1:0]  IN_TAG;
  logic [DATA_W-1:0] IN_DATA;
  logic [63:0]       FIRE, VALID;
  logic              MF, WR_E, DEL;
  logic [5:0]        ADDR;
  logic              OUT_VALID, OUT_READY;
  logic [TAG_W-1:0]  OUT_TAG;
  logic [DATA_W-1:0] OUT_DL, OUT_DR;
  logic              OVF;

  int vectors     = 0;
  int miscompares = 0;

  join_match_mem #(.ENTRIES(64), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .CP(CP), .MR(MR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_MF(IN_MF), .IN_LR(IN_LR),
    .IN_TAG(IN_TAG), .IN_DATA(IN_DATA),
    .FIRE(FIRE), .VALID(VALID), .MF(MF),
    .WR_E(WR_E), .DEL(DEL), .ADDR(ADDR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_TAG(OUT_TAG), .OUT_DL(OUT_DL), .OUT_DR(OUT_DR), .OVF(OVF)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one packet from IDLE at a falling edge, plays the controller
  // decision during LOOK/COMMIT and returns at the falling edge after COMMIT.
  task automatic send(input logic mf, input logic lr, input logic [TAG_W-1:0] tag,
                      input logic [DATA_W-1:0] data, input logic wr, input logic del,
                      input logic [5:0] addr, input logic [63:0] exp_fire);
    IN_VALID = 1'b1; IN_MF = mf; IN_LR = lr; IN_TAG = tag; IN_DATA = data;
    @(posedge CP); @(negedge CP);
    IN_VALID = 1'b0;
    check("look_fire", FIRE, exp_fire);
    check("look_mf", {63'd0, MF}, {63'd0, mf});
    check("look_in_ready", {63'd0, IN_READY}, 64'd0);
    WR_E = wr; DEL = del; ADDR = addr;
    @(posedge CP); @(negedge CP);
    check("commit_in_ready", {63'd0, IN_READY}, 64'd0);
    @(posedge CP); @(negedge CP);
    WR_E = 1'b0; DEL = 1'b0;
  endtask

  // Accepts the emitted packet and confirms the return to IDLE.
  task automatic drain();
    OUT_READY = 1'b1;
    @(posedge CP); @(negedge CP);
    OUT_READY = 1'b0;
    check("drain_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("drain_in_ready", {63'd0, IN_READY}, 64'd1);
  endtask

  logic [63:0] exp_vld;

  initial begin
    MR = 1'b1; IN_VALID = 1'b0; IN_MF = 1'b0; IN_LR = 1'b0; IN_TAG = '0; IN_DATA = '0;
    WR_E = 1'b0; DEL = 1'b0; ADDR = '0; OUT_READY = 1'b0;
    exp_vld = '0;

    // Reset state.
    @(negedge CP); @(negedge CP);
    check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("rst_valid", VALID, 64'd0);
    check("rst_fire", FIRE, 64'd0);
    check("rst_mf", {63'd0, MF}, 64'd1);
    check("rst_ovf", {63'd0, OVF}, 64'd0);
    MR = 1'b0;
    @(negedge CP);
    check("post_rst_in_ready", {63'd0, IN_READY}, 64'd1);

    // Store a left operand in entry 0.
    send(1'b1, 1'b0, 10'h005, 16'h1111, 1'b1, 1'b0, 6'd0, 64'd0);
    check("store_valid", VALID, 64'h1);
    check("store_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("store_in_ready", {63'd0, IN_READY}, 64'd1);

    // Matching right operand joins entry 0.
    send(1'b1, 1'b1, 10'h005, 16'h2222, 1'b0, 1'b1, 6'd0, 64'h1);
    check("join_out_valid", {63'd0, OUT_VALID}, 64'd1);
    check("join_tag", {54'd0, OUT_TAG}, 64'h005);
    check("join_dl", {48'd0, OUT_DL}, 64'h1111);
    check("join_dr", {48'd0, OUT_DR}, 64'h2222);
    check("join_valid", VALID, 64'd0);
    drain();

    // Bypass with backpressure; stray WR_E during COMMIT must be ignored.
    send(1'b0, 1'b1, 10'h3FF, 16'hABCD, 1'b1, 1'b0, 6'd5, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", {63'd0, OUT_VALID}, 64'd1);
      check("bp_in_ready", {63'd0, IN_READY}, 64'd0);
      check("bp_tag", {54'd0, OUT_TAG}, 64'h3FF);
      check("bp_dl", {48'd0, OUT_DL}, 64'h0);
      check("bp_dr", {48'd0, OUT_DR}, 64'hABCD);
      check("bp_valid", VALID, 64'd0);
      @(negedge CP);
    end
    drain();

    // Fill all 64 entries with left TAG=0x01 operands.
    for (int i = 0; i < 64; i++) begin
      send(1'b1, 1'b0, 10'h001, 16'h1000 + 16'(i), 1'b1, 1'b0, 6'(i), 64'd0);
      exp_vld[i] = 1'b1;
      check("fill_valid", VALID, exp_vld);
    end
    check("fill_ovf", {63'd0, OVF}, 64'd0);

    // Overflow: one more store is dropped and flags stay all-ones.
    send(1'b1, 1'b0, 10'h002, 16'h2BAD, 1'b1, 1'b0, 6'd0, 64'd0);
    check("ovf_set", {63'd0, OVF}, 64'd1);
    check("ovf_valid", VALID, {64{1'b1}});
    check("ovf_out_valid", {63'd0, OUT_VALID}, 64'd0);

    // Right TAG=0x01 fires every entry; controller consumes entry 0 only.
    send(1'b1, 1'b1, 10'h001, 16'h3333, 1'b0, 1'b1, 6'd0, {64{1'b1}});
    check("full_join_tag", {54'd0, OUT_TAG}, 64'h001);
    check("full_join_dl", {48'd0, OUT_DL}, 64'h1000);
    check("full_join_dr", {48'd0, OUT_DR}, 64'h3333);
    check("full_join_valid", VALID, {{63{1'b1}}, 1'b0});
    check("ovf_sticky", {63'd0, OVF}, 64'd1);
    drain();

    // Reset clears overflow and all entries.
    MR = 1'b1;
    @(negedge CP);
    check("mr_ovf", {63'd0, OVF}, 64'd0);
    check("mr_valid", VALID, 64'd0);
    MR = 1'b0;
    @(negedge CP);

    // Same-side operands never match.
    send(1'b1, 1'b0, 10'h007, 16'h0070, 1'b1, 1'b0, 6'd0, 64'd0);
    send(1'b1, 1'b0, 10'h007, 16'h0071, 1'b1, 1'b0, 6'd1, 64'd0);
    check("same_side_valid", VALID, 64'h3);

    // Reset during EMIT drops the packet and all entries at once.
    send(1'b0, 1'b0, 10'h0AA, 16'h5555, 1'b0, 1'b0, 6'd0, 64'd0);
    check("pre_mr_out_valid", {63'd0, OUT_VALID}, 64'd1);
    check("pre_mr_dl", {48'd0, OUT_DL}, 64'h5555);
    #1 MR = 1'b1;
    #1;
    check("mr_emit_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("mr_emit_valid", VALID, 64'd0);
    @(negedge CP);
    MR = 1'b0;
    @(negedge CP);
    check("mr_emit_in_ready", {63'd0, IN_READY}, 64'd1);
    check("mr_emit_out_valid2", {63'd0, OUT_VALID}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
